// File: rtl/spi_flash_word_reader.sv
// Mode-0 single-lane SPI NOR read initiator: READ (0x03) + address, then one DATA_BITS word.
// Optional FLASH_SEQ_READ_EN keeps cs asserted between sequential words (HELD state).
`ifndef XLEN
`define XLEN 64
`endif

module spi_flash_word_reader #(
  parameter int ADDR_BITS   = 24,
  parameter int DATA_BITS   = `XLEN,
  parameter int SCLK_HALF   = 1,
  parameter int CS_HIGH_MIN = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_BITS-1:0] req_addr,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [DATA_BITS-1:0] resp_data,
  output logic                 cs,
  output logic                 sclk,
  output logic                 si,
  input  logic                 so,
  output logic                 wp,
  output logic                 hold
);

`ifdef FLASH_SEQ_READ_EN
  localparam logic SEQ_EN = 1'b1;
`else
  localparam logic SEQ_EN = 1'b0;
`endif

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CMD  = 3'd1;
  localparam logic [2:0] ST_ADDR = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_FIN  = 3'd4;
  localparam logic [2:0] ST_RESP = 3'd5;
  localparam logic [2:0] ST_GAP  = 3'd6;
  localparam logic [2:0] ST_HELD = 3'd7;

  localparam int TXW = 8 + ADDR_BITS;
  localparam int PW  = $clog2(2 * SCLK_HALF) + 1;
  localparam int BW  = $clog2((ADDR_BITS > DATA_BITS) ? ADDR_BITS : DATA_BITS) + 1;
  localparam int GW  = $clog2(CS_HIGH_MIN + 1) + 1;

  localparam logic [7:0]           CMD_READ  = 8'h03;
  localparam logic [PW-1:0]        PH_RISE   = PW'(SCLK_HALF - 1);
  localparam logic [PW-1:0]        PH_LAST   = PW'(2 * SCLK_HALF - 1);
  localparam logic [BW-1:0]        CMD_LAST  = BW'(7);
  localparam logic [BW-1:0]        ADDR_LAST = BW'(ADDR_BITS - 1);
  localparam logic [BW-1:0]        DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [GW-1:0]        GAP_MAX   = GW'(CS_HIGH_MIN);
  localparam logic [GW-1:0]        GAP_NEED  = (CS_HIGH_MIN > 0) ? GW'(CS_HIGH_MIN - 1) : GW'(0);
  localparam logic [ADDR_BITS-1:0] ADDR_STEP = ADDR_BITS'(DATA_BITS / 8);

  logic [2:0]           state_q, state_d;
  logic [PW-1:0]        ph_q, ph_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [TXW-1:0]       tx_q, tx_d;
  logic [DATA_BITS-1:0] rx_q, rx_d;
  logic [ADDR_BITS-1:0] last_addr_q, last_addr_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic                 ready_en_q;
  logic                 cs_q, cs_d, sclk_q, sclk_d, si_q, si_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [DATA_BITS-1:0] resp_data_q, resp_data_d;

  logic [TXW-1:0]       load_s;
  logic [DATA_BITS-1:0] swapped_s;
  logic                 seq_hit_s, gap_ok_s, req_ready_s, rise_s, bit_end_s;

  assign seq_hit_s   = SEQ_EN && (req_addr == last_addr_q + ADDR_STEP);
  assign gap_ok_s    = (gap_q >= GAP_NEED);
  assign req_ready_s = ready_en_q && (((state_q == ST_IDLE) && gap_ok_s) ||
                                      ((state_q == ST_HELD) && seq_hit_s));
  assign rise_s      = (ph_q == PH_RISE);
  assign bit_end_s   = (ph_q == PH_LAST);
  assign load_s      = {CMD_READ, req_addr};

  // Bytes arrive first-byte-first into the top of rx_q; repack little-endian.
  always_comb begin
    swapped_s = '0;
    for (int k = 0; k < DATA_BITS / 8; k++) begin
      swapped_s[8*k +: 8] = rx_q[DATA_BITS-8-8*k +: 8];
    end
  end

  always_comb begin
    state_d      = state_q;
    ph_d         = ph_q;
    bit_d        = bit_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    last_addr_d  = last_addr_q;
    cs_d         = cs_q;
    sclk_d       = sclk_q;
    si_d         = si_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    // gap_q counts clk edges since cs last rose, saturating at CS_HIGH_MIN
    if (!cs_q) begin
      gap_d = '0;
    end else if (gap_q != GAP_MAX) begin
      gap_d = gap_q + GW'(1);
    end else begin
      gap_d = gap_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_s) begin
          state_d     = ST_CMD;
          cs_d        = 1'b0;
          ph_d        = '0;
          bit_d       = '0;
          si_d        = load_s[TXW-1];
          tx_d        = load_s << 1;
          last_addr_d = req_addr;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CMD, ST_ADDR, ST_DATA: begin
        ph_d = ph_q + PW'(1);
        if (rise_s) begin
          sclk_d = 1'b1;
          if (state_q == ST_DATA) begin
            rx_d = {rx_q[DATA_BITS-2:0], so};
          end else begin
            rx_d = rx_q;
          end
        end else if (bit_end_s) begin
          sclk_d = 1'b0;
          ph_d   = '0;
          si_d   = tx_q[TXW-1];
          tx_d   = tx_q << 1;
          bit_d  = bit_q + BW'(1);
          if ((state_q == ST_CMD) && (bit_q == CMD_LAST)) begin
            state_d = ST_ADDR;
            bit_d   = '0;
          end else if ((state_q == ST_ADDR) && (bit_q == ADDR_LAST)) begin
            state_d = ST_DATA;
            bit_d   = '0;
          end else if ((state_q == ST_DATA) && (bit_q == DATA_LAST)) begin
            state_d = ST_FIN;
            bit_d   = '0;
          end else begin
            state_d = state_q;
          end
        end else begin
          sclk_d = sclk_q;
        end
      end
      ST_FIN: begin
        cs_d         = ~SEQ_EN;
        resp_valid_d = 1'b1;
        resp_data_d  = swapped_s;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = SEQ_EN ? ST_HELD : ST_GAP;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_GAP: begin
        cs_d    = 1'b1;
        state_d = ST_IDLE;
      end
      ST_HELD: begin
        // sequential hit continues the open READ stream straight into DATA
        if (req_valid && req_ready_s) begin
          state_d     = ST_DATA;
          ph_d        = '0;
          bit_d       = '0;
          last_addr_d = req_addr;
        end else if (req_valid) begin
          cs_d    = 1'b1;
          state_d = ST_GAP;
        end else begin
          state_d = ST_HELD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cs_d    = 1'b1;
        sclk_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      ph_q         <= '0;
      bit_q        <= '0;
      tx_q         <= '0;
      rx_q         <= '0;
      last_addr_q  <= '0;
      gap_q        <= '0;
      ready_en_q   <= 1'b0;
      cs_q         <= 1'b1;
      sclk_q       <= 1'b0;
      si_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      ph_q         <= ph_d;
      bit_q        <= bit_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      last_addr_q  <= last_addr_d;
      gap_q        <= gap_d;
      ready_en_q   <= 1'b1;
      cs_q         <= cs_d;
      sclk_q       <= sclk_d;
      si_q         <= si_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign req_ready  = req_ready_s;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign cs         = cs_q;
  assign sclk       = sclk_q;
  assign si         = si_q;
  assign wp         = 1'b1;
  assign hold       = 1'b1;

endmodule

// File: tb/tb_spi_flash_word_reader.sv
// Scoreboard bench for spi_flash_word_reader with a behavioural serial-flash model.
module tb_spi_flash_word_reader;
  localparam int AB       = 24;
  localparam int DB       = 64;
  localparam int SH       = 1;
  localparam int CSM      = 2;
  localparam int FULL_LAT = 2 * SH * (8 + AB + DB) + 1;
  localparam int SEQ_LAT  = 2 * SH * DB + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AB-1:0] req_addr = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [DB-1:0] resp_data;
  logic          cs, sclk, si, wp, hold;
  logic          so = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    logic [AB-1:0] addr;
    logic [DB-1:0] data;
    int            acc;
    logic          cs_high;
  } exp_t;
  exp_t sb[$];

  spi_flash_word_reader #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .SCLK_HALF(SH), .CS_HIGH_MIN(CSM)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .cs(cs), .sclk(sclk), .si(si), .so(so), .wp(wp), .hold(hold)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Flash contents: the documented first eight bytes, a hash elsewhere.
  function automatic logic [7:0] mem_byte(input logic [AB-1:0] a);
    case (a)
      24'h000000: return 8'h6F;
      24'h000001: return 8'h00;
      24'h000002: return 8'h00;
      24'h000003: return 8'h10;
      24'h000004: return 8'h83;
      24'h000005: return 8'h00;
      24'h000006: return 8'h02;
      24'h000007: return 8'h01;
      default:    return (a[7:0] * 8'd29) ^ a[15:8] ^ a[23:16] ^ 8'hA5;
    endcase
  endfunction

  function automatic logic [DB-1:0] exp_word(input logic [AB-1:0] a);
    logic [DB-1:0] w;
    w = '0;
    for (int k = 0; k < DB / 8; k++) w[8*k +: 8] = mem_byte(a + AB'(k));
    return w;
  endfunction

  // Serial flash: samples si on sclk rise, shifts data out on sclk fall, streams while cs low.
  int            fbit = 0;
  logic [7:0]    f_cmd = '0;
  logic [AB-1:0] f_addr = '0;
  logic [7:0]    f_byte;
  logic          sclk_prev = 1'b0;
  initial forever begin
    @(sclk or cs);
    if (cs !== 1'b0) begin
      fbit = 0;
      so   = 1'b0;
    end else if (sclk === 1'b1 && sclk_prev === 1'b0) begin
      if (fbit < 8) f_cmd = {f_cmd[6:0], si};
      else if (fbit < 8 + AB) f_addr = {f_addr[AB-2:0], si};
      fbit++;
      if (fbit == 8 + AB) check("flash_cmd", 64'(f_cmd), 64'h03);
    end else if (sclk === 1'b0 && sclk_prev === 1'b1 && fbit >= 8 + AB) begin
      f_byte = mem_byte(f_addr + AB'((fbit - 8 - AB) / 8));
      so     = f_byte[7 - ((fbit - 8 - AB) % 8)];
    end
    sclk_prev = sclk;
  end

  // Monitor: pops the scoreboard when a response appears, then watches it stay put.
  logic          rv_prev = 1'b0;
  logic          cs_prev = 1'b1;
  int            cs_rise_cyc = 0;
  logic [DB-1:0] held = '0;
  exp_t          m_e;
  initial forever begin
    @(posedge clk);
    #1;
    if (resp_valid === 1'b1 && rv_prev !== 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", 64'd1, 64'd0);
      end else begin
        m_e = sb.pop_front();
        check("resp_data", resp_data, m_e.data);
        check("latency", 64'(cyc - m_e.acc), 64'(m_e.cs_high ? FULL_LAT : SEQ_LAT));
      end
      held = resp_data;
    end else if (resp_valid === 1'b1) begin
      check("hold_data", resp_data, held);
      check("hold_req_ready", 64'(req_ready), 64'd0);
      check("hold_sclk", 64'(sclk), 64'd0);
    end else if (rv_prev === 1'b1) begin
      check("drop_needs_ready", 64'(resp_ready), 64'd1);
    end
    if (cs === 1'b0 && cs_prev === 1'b1) check("cs_gap", 64'((cyc - cs_rise_cyc) >= CSM), 64'd1);
    if (cs === 1'b1 && cs_prev === 1'b0) cs_rise_cyc = cyc;
    rv_prev = resp_valid;
    cs_prev = cs;
  end

  logic [AB-1:0] last_addr = '0;

  task automatic run_txn(input logic [AB-1:0] addr, input int hold_cyc);
    int   t;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = addr;
    #1;
    t = 0;
    while (req_ready !== 1'b1 && t < 400) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (req_ready !== 1'b1) begin
      check("req_ready_timeout", 64'd0, 64'd1);
      req_valid = 1'b0;
      return;
    end
    e.addr    = addr;
    e.data    = exp_word(addr);
    e.acc     = cyc + 1;
    e.cs_high = cs;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = AB'($urandom);
    t = 0;
    while (resp_valid !== 1'b1 && t < 1000) begin
      resp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      t++;
    end
    resp_ready = 1'b0;
    if (resp_valid !== 1'b1) begin
      check("resp_timeout", 64'd0, 64'd1);
      return;
    end
    repeat (hold_cyc) @(negedge clk);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    last_addr = addr;
  endtask

  initial begin
    int t;
    logic [AB-1:0] a;
    rst       = 1'b0;
    req_valid = 1'b1;
    req_addr  = 24'h000123;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_cs", 64'(cs), 64'd1);
      check("rst_sclk", 64'(sclk), 64'd0);
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_resp_data", resp_data, 64'd0);
      check("rst_wp_hold", 64'({wp, hold}), 64'd3);
    end
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_rst", 64'(req_ready), 64'd1);

    run_txn(24'h000000, 2);
    run_txn(24'h000013, 20);
    run_txn(24'hFFFFFD, 0);

    // Abort during the address phase, then a clean read.
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 24'h000040;
    #1;
    t = 0;
    while (req_ready !== 1'b1 && t < 400) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("abort_accept", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_cs", 64'(cs), 64'd1);
    check("abort_sclk", 64'(sclk), 64'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    run_txn(24'h000008, 1);

    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 1) == 1) a = last_addr + AB'(DB / 8);
      else a = AB'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_txn(a, int'($urandom_range(0, 4)));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
